// File: rtl/mem_port_arbiter_if.sv
// Memory-side command/response bus of the IF/DM port arbiter.
// master: the arbiter driving commands; slave: the memory answering them.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  valid;
   logic                  we;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wmask;
   logic [DATA_W-1:0]     rdata;
   logic                  ack;

   modport master (
      output valid, we, addr, wdata, wmask,
      input  rdata, ack
   );

   modport slave (
      input  valid, we, addr, wdata, wmask,
      output rdata, ack
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch (IF)
// and data-memory (DM) ports of the pipeline. DM wins by default; a
// starvation counter forces an IF grant after STARVE_LIMIT consecutive DM
// grants while IF waits. An in-flight fetch can be squashed on flush.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   // instruction-fetch port
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ready,
   input  logic                flush_f,
   // data-memory port
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_wmask,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_ready,
   // pipeline stalls
   output logic                stall_f,
   output logic                stall_m,
   // shared memory
   mem_port_arbiter_if.master  mem
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, DONE} state_t;

   state_t              state_q, state_d;
   logic                grant_dm, grant_if;
   logic [CNT_W-1:0]    starve_cnt_q;
   logic                squash_q;

   logic                mem_valid_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [DATA_W/8-1:0] mem_wmask_q;
   logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;
   logic                if_ready_q, dm_ready_q;

   // Grant decision and next state; grants are only made from IDLE.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      grant_dm = 1'b0;
      grant_if = 1'b0;
      state_d  = state_q;
      case (state_q)
         IDLE: begin
            grant_dm = dm_req && (!if_req || (starve_cnt_q < LIMIT));
            grant_if = !grant_dm && if_req && !flush_f;
            if (grant_dm)      state_d = BUSY_DM;
            else if (grant_if) state_d = BUSY_IF;
         end
         BUSY_IF, BUSY_DM: begin
            if (mem.ack) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Command latch, response capture, starvation counter and squash flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_valid_q  <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wmask_q  <= '0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
         if_ready_q   <= 1'b0;
         dm_ready_q   <= 1'b0;
         starve_cnt_q <= '0;
         squash_q     <= 1'b0;
      end else begin
         // readies are single-cycle pulses unless set below
         if_ready_q <= 1'b0;
         dm_ready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_dm) begin
                  mem_valid_q <= 1'b1;
                  mem_we_q    <= dm_we;
                  mem_addr_q  <= dm_addr;
                  mem_wdata_q <= dm_wdata;
                  mem_wmask_q <= dm_wmask;
               end else if (grant_if) begin
                  mem_valid_q <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= if_addr;
                  mem_wmask_q <= '0;
               end
               // a DM grant only counts against IF when IF is really waiting
               if (grant_if || !if_req)
                  starve_cnt_q <= '0;
               else if (grant_dm && !flush_f && (starve_cnt_q != LIMIT))
                  starve_cnt_q <= starve_cnt_q + CNT_W'(1);
            end
            BUSY_IF: begin
               if (flush_f) squash_q <= 1'b1;
               if (mem.ack) begin
                  mem_valid_q <= 1'b0;
                  squash_q    <= 1'b0;
                  // a flush on the ack cycle itself also drops the fetch
                  if (!(squash_q || flush_f)) begin
                     if_rdata_q <= mem.rdata;
                     if_ready_q <= 1'b1;
                  end
               end
            end
            BUSY_DM: begin
               if (mem.ack) begin
                  mem_valid_q <= 1'b0;
                  dm_ready_q  <= 1'b1;
                  if (!mem_we_q) dm_rdata_q <= mem.rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem.valid = mem_valid_q;
   assign mem.we    = mem_we_q;
   assign mem.addr  = mem_addr_q;
   assign mem.wdata = mem_wdata_q;
   assign mem.wmask = mem_wmask_q;

   assign if_rdata  = if_rdata_q;
   assign if_ready  = if_ready_q;
   assign dm_rdata  = dm_rdata_q;
   assign dm_ready  = dm_ready_q;

   assign stall_f   = if_req & ~if_ready_q;
   assign stall_m   = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (STARVE_LIMIT = 4).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic                clk = 1'b0;
   logic                reset;
   logic                if_req, flush_f;
   logic [ADDR_W-1:0]   if_addr;
   logic [DATA_W-1:0]   if_rdata;
   logic                if_ready;
   logic                dm_req, dm_we;
   logic [ADDR_W-1:0]   dm_addr;
   logic [DATA_W-1:0]   dm_wdata;
   logic [DATA_W/8-1:0] dm_wmask;
   logic [DATA_W-1:0]   dm_rdata;
   logic                dm_ready;
   logic                stall_f, stall_m;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mbus ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_ready (if_ready),
      .flush_f  (flush_f),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_wmask (dm_wmask),
      .dm_rdata (dm_rdata),
      .dm_ready (dm_ready),
      .stall_f  (stall_f),
      .stall_m  (stall_m),
      .mem      (mbus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] starve_addr [6];
      starve_addr = '{32'h4000, 32'h4000, 32'h4000, 32'h4000, 32'h0200, 32'h4000};

      reset = 1'b1; if_req = 1'b0; flush_f = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wmask = '0;
      mbus.ack = 1'b0; mbus.rdata = '0;
      tick(); tick();
      reset = 1'b0;

      // reset state
      check("rst_mem_valid", mbus.valid, 0);
      check("rst_mem_addr",  mbus.addr, 0);
      check("rst_if_ready",  if_ready, 0);
      check("rst_dm_ready",  dm_ready, 0);
      check("rst_if_rdata",  if_rdata, 0);
      check("rst_dm_rdata",  dm_rdata, 0);

      // lone fetch, ack two cycles after mem_valid
      if_req = 1'b1; if_addr = 32'h100;
      #1 check("lone_stall_f_req", stall_f, 1);
      tick();
      check("lone_mem_valid", mbus.valid, 1);
      check("lone_mem_addr",  mbus.addr, 32'h100);
      check("lone_mem_we",    mbus.we, 0);
      check("lone_mem_wmask", mbus.wmask, 0);
      tick();
      check("lone_wait_valid", mbus.valid, 1);
      check("lone_wait_ready", if_ready, 0);
      check("lone_wait_stall", stall_f, 1);
      mbus.ack = 1'b1; mbus.rdata = 32'h00500093;
      tick();
      mbus.ack = 1'b0;
      check("lone_if_ready",  if_ready, 1);
      check("lone_if_rdata",  if_rdata, 32'h00500093);
      check("lone_valid_off", mbus.valid, 0);
      check("lone_stall_off", stall_f, 0);
      if_req = 1'b0;
      tick();
      check("lone_ready_pulse", if_ready, 0);

      // simultaneous requests: DM first, IF after DONE
      if_req = 1'b1; if_addr = 32'h104;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
      tick();
      check("sim_dm_addr",  mbus.addr, 32'h2000);
      check("sim_dm_valid", mbus.valid, 1);
      mbus.ack = 1'b1; mbus.rdata = 32'h11112222;
      tick();
      mbus.ack = 1'b0;
      check("sim_dm_ready", dm_ready, 1);
      check("sim_dm_rdata", dm_rdata, 32'h11112222);
      check("sim_if_not_yet", if_ready, 0);
      dm_req = 1'b0;
      tick();
      check("sim_done_no_grant", mbus.valid, 0);
      check("sim_dm_pulse", dm_ready, 0);
      tick();
      check("sim_if_addr",  mbus.addr, 32'h104);
      check("sim_if_valid", mbus.valid, 1);
      mbus.ack = 1'b1; mbus.rdata = 32'h33334444;
      tick();
      mbus.ack = 1'b0;
      check("sim_if_ready", if_ready, 1);
      check("sim_if_rdata", if_rdata, 32'h33334444);
      check("sim_dm_quiet", dm_ready, 0);
      if_req = 1'b0;
      tick();

      // store, with requester inputs changing mid-transaction
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h3004;
      dm_wdata = 32'hDEADBEEF; dm_wmask = 4'b0011;
      tick();
      check("st_mem_we",    mbus.we, 1);
      check("st_mem_addr",  mbus.addr, 32'h3004);
      check("st_mem_wdata", mbus.wdata, 32'hDEADBEEF);
      check("st_mem_wmask", mbus.wmask, 4'b0011);
      check("st_stall_m",   stall_m, 1);
      dm_addr = 32'h9999; dm_wdata = 32'h0; dm_wmask = 4'b1111;
      tick();
      check("st_hold_addr",  mbus.addr, 32'h3004);
      check("st_hold_wmask", mbus.wmask, 4'b0011);
      mbus.ack = 1'b1; mbus.rdata = 32'h55555555;
      tick();
      mbus.ack = 1'b0;
      check("st_dm_ready", dm_ready, 1);
      check("st_dm_rdata", dm_rdata, 32'h11112222);
      check("st_stall_m_off", stall_m, 0);
      dm_req = 1'b0; dm_we = 1'b0;
      tick();

      // starvation: four DM grants, one forced IF grant, then DM again
      if_req = 1'b1; if_addr = 32'h200;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("starve_addr_%0d", i), mbus.addr, starve_addr[i]);
         mbus.ack = 1'b1; mbus.rdata = 32'hA0000000 + i;
         tick();
         mbus.ack = 1'b0;
         check($sformatf("starve_if_ready_%0d", i), if_ready, (i == 4));
         check($sformatf("starve_dm_ready_%0d", i), dm_ready, (i != 4));
         tick();
      end
      if_req = 1'b0; dm_req = 1'b0;
      check("starve_if_rdata", if_rdata, 32'hA0000004);
      check("starve_dm_rdata", dm_rdata, 32'hA0000005);

      // flush in IDLE suppresses the grant; flush in BUSY_IF squashes it
      if_req = 1'b1; if_addr = 32'h300; flush_f = 1'b1;
      tick();
      check("flush_idle_no_grant", mbus.valid, 0);
      flush_f = 1'b0;
      tick();
      check("flush_grant_valid", mbus.valid, 1);
      check("flush_grant_addr",  mbus.addr, 32'h300);
      flush_f = 1'b1;
      tick();
      flush_f = 1'b0; if_req = 1'b0;
      mbus.ack = 1'b1; mbus.rdata = 32'hBADBAD00;
      tick();
      mbus.ack = 1'b0;
      check("flush_no_ready",  if_ready, 0);
      check("flush_rdata_kept", if_rdata, 32'hA0000004);
      check("flush_valid_off", mbus.valid, 0);
      tick();
      check("flush_no_ready_late", if_ready, 0);
      // IDLE two cycles after the ack: a new DM request is granted at once
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h5000;
      tick();
      check("flush_idle_valid", mbus.valid, 1);
      check("flush_idle_addr",  mbus.addr, 32'h5000);

      // reset in the middle of the DM transaction, then a late ack
      reset = 1'b1; dm_req = 1'b0;
      tick();
      reset = 1'b0;
      check("mid_rst_valid",    mbus.valid, 0);
      check("mid_rst_addr",     mbus.addr, 0);
      check("mid_rst_if_rdata", if_rdata, 0);
      check("mid_rst_dm_rdata", dm_rdata, 0);
      check("mid_rst_dm_ready", dm_ready, 0);
      mbus.ack = 1'b1; mbus.rdata = 32'h77777777;
      tick();
      mbus.ack = 1'b0;
      check("late_ack_dm_ready", dm_ready, 0);
      check("late_ack_if_ready", if_ready, 0);
      check("late_ack_dm_rdata", dm_rdata, 0);
      tick();
      check("late_ack_dm_ready2", dm_ready, 0);
      check("late_ack_valid",     mbus.valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the instruction-fetch port (IF) and the data-memory port (DM) of the 5-stage RISC-V pipeline.
- Registers the winning request, holds the memory command stable until acknowledge, and returns read data and a one-cycle ready pulse to the owner.
- DM (older instruction) has priority; a starvation limit guarantees forward progress for IF.
- Supports squashing an in-flight fetch on pipeline flush.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, max consecutive DM grants while IF is pending before IF is forced a grant (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, registered
- if_ready  out  1  one-cycle pulse: if_rdata valid
- flush_f  in  1  squash any pending or in-flight fetch
- dm_req  in  1  data request, held until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_wmask  in  DATA_W/8  byte enables for stores
- dm_rdata  out  DATA_W  load data, registered
- dm_ready  out  1  one-cycle pulse: access complete
- mem_valid  out  1  command valid, held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  latched command
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory
- stall_f  out  1  comb: if_req & ~if_ready
- stall_m  out  1  comb: dm_req & ~dm_ready

Behaviour:
- Reset: state IDLE; all registered outputs 0 (mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask, if_rdata, if_ready, dm_rdata, dm_ready); starvation counter 0; squash flag 0.
- States: IDLE, BUSY_IF, BUSY_DM, DONE.
- IDLE, grant decision at cycle T:
  - dm_req=1 and (if_req=0 or cnt<STARVE_LIMIT): grant DM.
  - Else if if_req=1 and flush_f=0: grant IF.
  - Grant latches the command into mem_* registers; at T+1 state is BUSY_x and mem_valid=1.
  - IF grant sets mem_we=0 and mem_wmask=0.
- Starvation counter (width clog2(STARVE_LIMIT+1)):
  - Increments on a DM grant while if_req=1 and flush_f=0.
  - Clears on an IF grant or when if_req=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- BUSY_x:
  - mem_* held constant; requester input changes are ignored.
  - On mem_ack, mem_valid=0 next cycle and state goes to DONE.
  - Loads capture mem_rdata into the owner's rdata register, and the owner's ready is 1 in DONE.
  - Stores leave dm_rdata unchanged and pulse dm_ready.
- Minimum latency: request at T, mem_ack at T+1 → ready at T+2. Ack latency L cycles after mem_valid gives ready at T+1+L.
- DONE: one cycle, no grants; the just-served requester's still-high req is ignored. Next state is IDLE. Back-to-back throughput is one access per 3 cycles minimum.
- flush_f:
  - In IDLE it suppresses an IF grant that cycle.
  - In BUSY_IF it sets the squash flag. The memory transaction still completes (no abort), but on ack if_rdata is not updated and if_ready stays 0. The flag clears on entering DONE.
  - Has no effect on DM transactions.
- mem_ack outside BUSY_x is ignored.
- Reset mid-transaction: next cycle everything returns to reset values; a late mem_ack is ignored.
- Each ready is a single-cycle pulse; both never assert in the same cycle.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x100, mem_ack 2 cycles after mem_valid with mem_rdata=0x00500093 → mem_addr=0x100, mem_we=0; if_ready pulses once with if_rdata=0x00500093; stall_f high until then.
- Simultaneous: if_req and dm_req (load 0x2000) in IDLE, ack latency 1 → DM served first (dm_ready at cycle 2), IF granted in the IDLE after DONE; if_ready at cycle 5.
- Starvation (STARVE_LIMIT=4): if_req and dm_req held high, DM re-requests after each ready → exactly 4 DM grants, then an IF grant, then DM resumes.
- Store: dm_we=1, dm_addr=0x3004, dm_wdata=0xDEADBEEF, dm_wmask=4'b0011 → mem_* carry those values; dm_ready pulses; dm_rdata unchanged.
- Flush in flight: fetch granted, flush_f pulsed in BUSY_IF, then mem_ack → no if_ready, if_rdata unchanged, state IDLE two cycles after ack.
- Reset mid-op: reset during BUSY_DM → next cycle mem_valid=0, all outputs 0; a later mem_ack produces no ready.
